// File: rtl/sequential_divider.sv
// sequential_divider: radix-2 restoring signed divider, one quotient bit per enabled clock.
// Ports: clk, reset (async, active-high), enable (holds all state when low),
//   start/dividend/divisor (request and operands, sampled in IDLE),
//   busy, done (one-cycle pulse), quotient, remainder, div_by_zero (held until the next result).
// Optional: define DIV_UNSIGNED_SEL_EN to add input is_signed (0 = unsigned operation).
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_SEL_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] rem, q, dvs;
  logic q_neg, r_neg, dz, sgn, a_neg, b_neg;
  logic [WIDTH:0] upper, trial;
`ifdef DIV_UNSIGNED_SEL_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b1;
`endif
  assign a_neg = sgn & dividend[WIDTH-1];
  assign b_neg = sgn & divisor[WIDTH-1];
  // shifted partial remainder; a borrow out of bit WIDTH means the trial went negative
  assign upper = {rem, q[WIDTH-1]};
  assign trial = upper - {1'b0, dvs};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      q           <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy        <= 1'b1;
          div_by_zero <= 1'b0;
          count       <= '0;
          dz          <= divisor == '0;
          dvs         <= b_neg ? -divisor : divisor;
          // divide-by-zero skips RUN and preloads the fixed result with no sign correction
          if (divisor == '0) begin
            rem   <= dividend;
            q     <= '1;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            state <= FIX;
          end else begin
            rem   <= '0;
            q     <= a_neg ? -dividend : dividend;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            state <= RUN;
          end
        end
        RUN: begin
          rem   <= trial[WIDTH] ? upper[WIDTH-1:0] : trial[WIDTH-1:0];
          q     <= {q[WIDTH-2:0], ~trial[WIDTH]};
          count <= count + 1'b1;
          state <= count == CW'(WIDTH - 1) ? FIX : RUN;
        end
        FIX: begin
          quotient    <= q_neg ? -q : q;
          remainder   <= r_neg ? -rem : rem;
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
Radix-2 restoring sequential divider. It is the inverse-operation companion to the registered sequential multiplier in the same arithmetic block set. It takes a signed WIDTH-bit dividend and divisor on a start pulse, iterates one quotient bit per clock, and presents a registered quotient and remainder with a one-cycle done pulse. It sits behind the same operand registers as the multiplier and shares its enable gating.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits; legal range 4..64.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high; clears all state and outputs.
enable  input  1  when low, all state (FSM, counter, datapath, outputs) holds.
start  input  1  request; sampled only in IDLE with enable=1.
dividend  input  WIDTH  signed two's-complement dividend, sampled with start.
divisor  input  WIDTH  signed two's-complement divisor, sampled with start.
busy  output  1  high from the cycle after start acceptance until done is asserted.
done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid from this cycle.
quotient  output  WIDTH  signed quotient, truncated toward zero.
remainder  output  WIDTH  signed remainder; its sign follows the dividend.
div_by_zero  output  1  set with done when divisor==0; cleared on the next start acceptance.

Behaviour:
- Reset (async):
  - FSM goes to IDLE; iteration counter = 0.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Reset mid-operation aborts the operation. No done pulse is produced.
- FSM states: IDLE, RUN, FIX.
  - IDLE: on edge E0 with start=1 and enable=1, latch operands.
    - If divisor==0, go to FIX.
    - Otherwise go to RUN with count=0.
    - The magnitudes |dividend| and |divisor| are computed at latch time.
    - The sign flags (quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend)) are stored.
  - RUN: each enabled edge performs one restoring step:
    - shift {rem, q} left by 1;
    - trial = rem - |divisor|, computed in WIDTH+1 bits;
    - if trial is non-negative, rem = trial and the q LSB = 1;
    - count increments.
    - After WIDTH steps (edge EW) go to FIX.
  - FIX: one enabled edge. It applies the sign correction (two's-complement negate where the sign flag is set), registers quotient and remainder, pulses done=1, drops busy and returns to IDLE.
- Latency:
  - done is high in the cycle after edge E(WIDTH+1), i.e. WIDTH+2 enabled edges after start acceptance.
  - Divide-by-zero: done after 2 enabled edges.
  - enable-low cycles extend the latency one-for-one.
- Held outputs: quotient, remainder and div_by_zero hold their values until the next FIX. Starting a new operation does not clear them, except div_by_zero, which clears at acceptance.
- start while busy (RUN/FIX) is ignored. No queuing.
- start asserted in the same cycle that done is high: accepted, because the FSM is already in IDLE.
- Divide-by-zero result: quotient = all ones (-1), remainder = dividend unchanged, div_by_zero=1.
- Overflow (MIN / -1): quotient wraps to MIN (e.g. -2147483648 for WIDTH=32), remainder=0. No error flag.
- Width rule: magnitudes are handled in WIDTH bits as unsigned, so |MIN| = 2^(WIDTH-1) is representable. The negation in FIX is modulo 2^WIDTH.

Optional Feature:
- Macro DIV_UNSIGNED_SEL_EN.
- When defined:
  - an extra input port is_signed (1 bit) is sampled with start;
  - is_signed=0 treats both operands as unsigned (no magnitude conversion, no sign correction);
  - divide-by-zero gives quotient = all ones and remainder = dividend.
- When undefined: the port is absent and every operation is signed.

Test Plan:
- Reset mid-RUN: dividend=100, divisor=7; assert reset at cycle 10 -> busy=0, done never pulses, quotient=0, remainder=0.
- Basic signed cases, WIDTH=32, done exactly 34 edges after start:
  - 100/7 -> quotient 14, remainder 2;
  - -100/7 -> quotient -14, remainder -2;
  - 100/-7 -> quotient -14, remainder 2;
  - -100/-7 -> quotient 14, remainder -2.
- Boundaries:
  - -2147483648/-1 -> quotient -2147483648, remainder 0;
  - 2147483647/1 -> quotient 2147483647, remainder 0;
  - 0/5 -> quotient 0, remainder 0;
  - 3/300 -> quotient 0, remainder 3.
- Divide by zero: -25/0 -> done after 2 edges, quotient=-1, remainder=-25, div_by_zero=1. The next start of 40/4 clears div_by_zero and gives quotient=10.
- Handshake:
  - start pulsed during RUN -> ignored, and the first result is unchanged;
  - start held high on the done cycle -> back-to-back result with no idle gap;
  - enable low for 5 cycles mid-RUN -> done delayed by exactly 5 cycles.
- With DIV_UNSIGNED_SEL_EN defined, is_signed=0: 0xFFFFFFFF/2 -> quotient 0x7FFFFFFF, remainder 1. The same operands with is_signed=1 -> quotient 0, remainder -1.
